// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush, PC redirect sequencing,
// fence.i cache maintenance handshakes and stall/redirect performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_busy_i,
    input  logic             if_resp_valid_i,
    input  logic             load_use_i,
    input  logic             ex_busy_i,
    input  logic             mem_busy_i,
    input  logic             mispredict_i,
    input  logic [XLEN-1:0]  mispredict_pc_i,
    input  logic             trap_i,
    input  logic [XLEN-1:0]  trap_pc_i,
    input  logic             fencei_i,
    input  logic [XLEN-1:0]  fencei_pc_i,
    input  logic             dcache_flush_done_i,
    input  logic             icache_inv_done_i,
    output logic             stall_pc_o,
    output logic             stall_if_id_o,
    output logic             flush_if_id_o,
    output logic             stall_id_ex_o,
    output logic             flush_id_ex_o,
    output logic             stall_ex_mem_o,
    output logic             flush_ex_mem_o,
    output logic             stall_mem_wb_o,
    output logic             flush_mem_wb_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             dcache_flush_req_o,
    output logic             icache_inv_req_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_FETCH = 2'd1,
        ST_FENCE_D    = 2'd2,
        ST_FENCE_I    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pending_pc_q, pending_pc_d;
    logic              resp_seen_q, resp_seen_d;
    logic [CNT_W-1:0]  stall_cnt_q, redirect_cnt_q;

    logic s_pc, s_if_id, s_id_ex, s_ex_mem, s_mem_wb;
    logic f_if_id, f_id_ex, f_ex_mem, f_mem_wb;
    logic redir, dreq, ireq;
    logic [XLEN-1:0] rpc;

    logic trap_acc, fencei_acc, mp_acc;

    // Events are only taken while MEM can advance; trap > fence.i > mispredict
    assign trap_acc   = trap_i & ~mem_busy_i;
    assign fencei_acc = fencei_i & ~mem_busy_i & ~trap_i;
    assign mp_acc     = mispredict_i & ~mem_busy_i & ~trap_i & ~fencei_i;

    // Next-state and raw (pre-priority) control generation
    always_comb begin
        state_d      = state_q;
        pending_pc_d = pending_pc_q;
        resp_seen_d  = resp_seen_q;
        s_pc = 1'b0; s_if_id = 1'b0; s_id_ex = 1'b0; s_ex_mem = 1'b0; s_mem_wb = 1'b0;
        f_if_id = 1'b0; f_id_ex = 1'b0; f_ex_mem = 1'b0; f_mem_wb = 1'b0;
        redir = 1'b0;
        rpc   = '0;
        dreq  = 1'b0;
        ireq  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (trap_acc || mp_acc) begin
                    f_if_id  = 1'b1;
                    f_id_ex  = 1'b1;
                    f_ex_mem = trap_acc;
                    if (if_busy_i) begin
                        pending_pc_d = trap_acc ? trap_pc_i : mispredict_pc_i;
                        resp_seen_d  = 1'b0;
                        state_d      = ST_WAIT_FETCH;
                    end else begin
                        redir = 1'b1;
                        rpc   = trap_acc ? trap_pc_i : mispredict_pc_i;
                    end
                end else if (fencei_acc) begin
                    f_if_id      = 1'b1;
                    f_id_ex      = 1'b1;
                    f_ex_mem     = 1'b1;
                    pending_pc_d = fencei_pc_i;
                    state_d      = ST_FENCE_D;
                end else if (mem_busy_i) begin
                    s_pc = 1'b1; s_if_id = 1'b1; s_id_ex = 1'b1; s_ex_mem = 1'b1; s_mem_wb = 1'b1;
                end else if (ex_busy_i) begin
                    s_pc = 1'b1; s_if_id = 1'b1; s_id_ex = 1'b1;
                    f_ex_mem = 1'b1;
                end else if (load_use_i) begin
                    s_pc = 1'b1; s_if_id = 1'b1;
                    f_id_ex = 1'b1;
                end else if (if_busy_i) begin
                    s_pc    = 1'b1;
                    f_if_id = 1'b1;
                end
            end
            ST_WAIT_FETCH: begin
                // Hold PC and discard whatever the stale fetch delivers
                s_pc    = 1'b1;
                f_if_id = 1'b1;
                if (trap_acc) begin
                    f_id_ex      = 1'b1;
                    f_ex_mem     = 1'b1;
                    pending_pc_d = trap_pc_i;
                end
                if (resp_seen_q) begin
                    redir       = 1'b1;
                    rpc         = trap_acc ? trap_pc_i : pending_pc_q;
                    resp_seen_d = 1'b0;
                    state_d     = ST_RUN;
                end else if (if_resp_valid_i || !if_busy_i) begin
                    resp_seen_d = 1'b1;
                end
            end
            ST_FENCE_D: begin
                s_pc = 1'b1; f_if_id = 1'b1; f_id_ex = 1'b1;
                dreq = 1'b1;
                if (dcache_flush_done_i) state_d = ST_FENCE_I;
            end
            ST_FENCE_I: begin
                s_pc = 1'b1; f_if_id = 1'b1; f_id_ex = 1'b1;
                ireq = 1'b1;
                if (icache_inv_done_i) begin
                    // Idle fetch redirects next cycle; busy fetch waits for its response
                    resp_seen_d = ~if_busy_i;
                    state_d     = ST_WAIT_FETCH;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output gating: reset forces zero, flush overrides stall on the same register
    assign stall_pc_o         = rst & s_pc;
    assign stall_if_id_o      = rst & s_if_id  & ~f_if_id;
    assign flush_if_id_o      = rst & f_if_id;
    assign stall_id_ex_o      = rst & s_id_ex  & ~f_id_ex;
    assign flush_id_ex_o      = rst & f_id_ex;
    assign stall_ex_mem_o     = rst & s_ex_mem & ~f_ex_mem;
    assign flush_ex_mem_o     = rst & f_ex_mem;
    assign stall_mem_wb_o     = rst & s_mem_wb & ~f_mem_wb;
    assign flush_mem_wb_o     = rst & f_mem_wb;
    assign redirect_valid_o   = rst & redir;
    assign redirect_pc_o      = rst ? rpc : '0;
    assign dcache_flush_req_o = rst & dreq;
    assign icache_inv_req_o   = rst & ireq;
    assign stall_cnt_o        = stall_cnt_q;
    assign redirect_cnt_o     = redirect_cnt_q;

    // State, pending target and performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            pending_pc_q   <= '0;
            resp_seen_q    <= 1'b0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_pc_q <= pending_pc_d;
            resp_seen_q  <= resp_seen_d;
            if (stall_pc_o)       stall_cnt_q    <= stall_cnt_q + CNT_W'(1);
            if (redirect_valid_o) redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an expected-output scoreboard queue.
module tb_pipe_hazard_ctrl;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic            stall_pc;
        logic            stall_if_id;
        logic            flush_if_id;
        logic            stall_id_ex;
        logic            flush_id_ex;
        logic            stall_ex_mem;
        logic            flush_ex_mem;
        logic            stall_mem_wb;
        logic            flush_mem_wb;
        logic            redir;
        logic            dreq;
        logic            ireq;
        logic [XLEN-1:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic if_busy_i = 0, if_resp_valid_i = 0, load_use_i = 0, ex_busy_i = 0, mem_busy_i = 0;
    logic mispredict_i = 0, trap_i = 0, fencei_i = 0;
    logic [XLEN-1:0] mispredict_pc_i = '0, trap_pc_i = '0, fencei_pc_i = '0;
    logic dcache_flush_done_i = 0, icache_inv_done_i = 0;

    logic stall_pc_o, stall_if_id_o, flush_if_id_o, stall_id_ex_o, flush_id_ex_o;
    logic stall_ex_mem_o, flush_ex_mem_o, stall_mem_wb_o, flush_mem_wb_o;
    logic redirect_valid_o, dcache_flush_req_o, icache_inv_req_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] stall_cnt_o, redirect_cnt_o;

    int errors = 0;
    int checks = 0;
    exp_t sb_q[$];
    logic [CNT_W-1:0] m_stall_cnt = '0;
    logic [CNT_W-1:0] m_redir_cnt = '0;
    exp_t e;

    pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_busy_i(if_busy_i), .if_resp_valid_i(if_resp_valid_i),
        .load_use_i(load_use_i), .ex_busy_i(ex_busy_i), .mem_busy_i(mem_busy_i),
        .mispredict_i(mispredict_i), .mispredict_pc_i(mispredict_pc_i),
        .trap_i(trap_i), .trap_pc_i(trap_pc_i),
        .fencei_i(fencei_i), .fencei_pc_i(fencei_pc_i),
        .dcache_flush_done_i(dcache_flush_done_i), .icache_inv_done_i(icache_inv_done_i),
        .stall_pc_o(stall_pc_o),
        .stall_if_id_o(stall_if_id_o), .flush_if_id_o(flush_if_id_o),
        .stall_id_ex_o(stall_id_ex_o), .flush_id_ex_o(flush_id_ex_o),
        .stall_ex_mem_o(stall_ex_mem_o), .flush_ex_mem_o(flush_ex_mem_o),
        .stall_mem_wb_o(stall_mem_wb_o), .flush_mem_wb_o(flush_mem_wb_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .dcache_flush_req_o(dcache_flush_req_o), .icache_inv_req_o(icache_inv_req_o),
        .stall_cnt_o(stall_cnt_o), .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    // One cycle: queue the expectation, sample mid-cycle, compare, then advance the counter model
    task automatic step(input exp_t ex, input string tag);
        exp_t exp_v, obs;
        sb_q.push_back(ex);
        #1;
        obs = '{stall_pc_o, stall_if_id_o, flush_if_id_o, stall_id_ex_o, flush_id_ex_o,
                stall_ex_mem_o, flush_ex_mem_o, stall_mem_wb_o, flush_mem_wb_o,
                redirect_valid_o, dcache_flush_req_o, icache_inv_req_o, redirect_pc_o};
        exp_v = sb_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, obs, exp_v);
        end
        checks++;
        assert (stall_cnt_o === m_stall_cnt) else begin
            errors++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt_o, m_stall_cnt);
        end
        checks++;
        assert (redirect_cnt_o === m_redir_cnt) else begin
            errors++;
            $error("FAIL %s redirect_cnt observed=%0d expected=%0d", tag, redirect_cnt_o, m_redir_cnt);
        end
        @(posedge clk);
        if (!rst) begin
            m_stall_cnt = '0;
            m_redir_cnt = '0;
        end else begin
            if (exp_v.stall_pc) m_stall_cnt = m_stall_cnt + CNT_W'(1);
            if (exp_v.redir)    m_redir_cnt = m_redir_cnt + CNT_W'(1);
        end
        @(negedge clk);
    endtask

    initial begin
        // Settle reset before any check
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Outputs forced low while in reset even with a hazard present
        load_use_i = 1; if_busy_i = 1;
        e = '0; step(e, "reset");
        load_use_i = 0; if_busy_i = 0; rst = 1'b1;
        e = '0; step(e, "idle");

        load_use_i = 1;
        e = '0; e.stall_pc = 1; e.stall_if_id = 1; e.flush_id_ex = 1; step(e, "load_use");
        load_use_i = 0;
        e = '0; step(e, "after_lu");

        mem_busy_i = 1; mispredict_i = 1; mispredict_pc_i = 64'h1234;
        e = '0; e.stall_pc = 1; e.stall_if_id = 1; e.stall_id_ex = 1; e.stall_ex_mem = 1; e.stall_mem_wb = 1;
        step(e, "mem_busy_gate");
        mem_busy_i = 0; mispredict_i = 0; ex_busy_i = 1;
        e = '0; e.stall_pc = 1; e.stall_if_id = 1; e.stall_id_ex = 1; e.flush_ex_mem = 1; step(e, "ex_busy");
        ex_busy_i = 0; if_busy_i = 1;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; step(e, "if_busy");

        // Same-cycle redirect with fetch idle
        if_busy_i = 0; mispredict_i = 1; mispredict_pc_i = 64'h8000_0100;
        e = '0; e.redir = 1; e.rpc = 64'h8000_0100; e.flush_if_id = 1; e.flush_id_ex = 1; step(e, "mp_direct");
        mispredict_i = 0;
        e = '0; step(e, "after_mp");

        // Deferred redirect behind an outstanding fetch
        mispredict_i = 1; mispredict_pc_i = 64'h100; if_busy_i = 1;
        e = '0; e.flush_if_id = 1; e.flush_id_ex = 1; step(e, "mp_defer");
        mispredict_i = 0;
        for (int i = 0; i < 3; i++) begin
            e = '0; e.stall_pc = 1; e.flush_if_id = 1; step(e, "wait_busy");
        end
        if_busy_i = 0; if_resp_valid_i = 1;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; step(e, "wait_resp");
        if_resp_valid_i = 0;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; e.redir = 1; e.rpc = 64'h100; step(e, "wait_redir");
        e = '0; step(e, "one_pulse");

        // Trap overwrites the pending target while waiting
        mispredict_i = 1; mispredict_pc_i = 64'h100; if_busy_i = 1;
        e = '0; e.flush_if_id = 1; e.flush_id_ex = 1; step(e, "mp_defer2");
        mispredict_i = 0; trap_i = 1; trap_pc_i = 64'h8000_0004;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; e.flush_id_ex = 1; e.flush_ex_mem = 1; step(e, "wait_trap");
        trap_i = 0; if_busy_i = 0; if_resp_valid_i = 1;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; step(e, "wait_resp2");
        if_resp_valid_i = 0;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; e.redir = 1; e.rpc = 64'h8000_0004; step(e, "trap_redir");
        e = '0; step(e, "idle2");

        // Trap beats a simultaneous mispredict
        trap_i = 1; trap_pc_i = 64'h8000_0040; mispredict_i = 1; mispredict_pc_i = 64'h500;
        e = '0; e.flush_if_id = 1; e.flush_id_ex = 1; e.flush_ex_mem = 1; e.redir = 1; e.rpc = 64'h8000_0040;
        step(e, "trap_prio");
        trap_i = 0; mispredict_i = 0;

        // fence.i: 5 cycles of dcache flush, 2 of icache invalidate, then redirect
        fencei_i = 1; fencei_pc_i = 64'h200;
        e = '0; e.flush_if_id = 1; e.flush_id_ex = 1; e.flush_ex_mem = 1; step(e, "fencei_acc");
        fencei_i = 0;
        for (int i = 0; i < 5; i++) begin
            dcache_flush_done_i = (i == 4);
            e = '0; e.stall_pc = 1; e.flush_if_id = 1; e.flush_id_ex = 1; e.dreq = 1; step(e, "fence_d");
        end
        dcache_flush_done_i = 0;
        for (int i = 0; i < 2; i++) begin
            icache_inv_done_i = (i == 1);
            e = '0; e.stall_pc = 1; e.flush_if_id = 1; e.flush_id_ex = 1; e.ireq = 1; step(e, "fence_i");
        end
        icache_inv_done_i = 0;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; e.redir = 1; e.rpc = 64'h200; step(e, "fence_redir");
        e = '0; step(e, "idle3");

        // Reset in the middle of FENCE_D with a gated mispredict pending
        fencei_i = 1; fencei_pc_i = 64'h300;
        e = '0; e.flush_if_id = 1; e.flush_id_ex = 1; e.flush_ex_mem = 1; step(e, "fencei_acc2");
        fencei_i = 0; mem_busy_i = 1; mispredict_i = 1; mispredict_pc_i = 64'h700;
        e = '0; e.stall_pc = 1; e.flush_if_id = 1; e.flush_id_ex = 1; e.dreq = 1; step(e, "fence_d_busy");
        rst = 1'b0;
        e = '0; step(e, "mid_reset");
        rst = 1'b1; mem_busy_i = 0; mispredict_i = 0;
        e = '0; step(e, "post_reset");
        load_use_i = 1;
        e = '0; e.stall_pc = 1; e.stall_if_id = 1; e.flush_id_ex = 1; step(e, "post_reset_run");
        load_use_i = 0;
        e = '0; step(e, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
